pipe_stage_skid_reg: RTL

//   Registered pipeline stage with a valid/ready handshake, a 2-entry skid buffer and

---
 rtl/pipe_stage_skid_reg_if.sv | 30 +++
 rtl/pipe_stage_skid_reg.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg_if.sv
// +----------------------------------------------------------------------------+
// | Module : pipe_stage_skid_reg_if                                            |
// | Brief  : valid/ready handshake bundle (with flush) around one pipe stage   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pipe_stage_skid_reg_if #(
  parameter int BITS = 32
);
  logic [BITS-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            flush;

  modport master (
    output in_data, in_valid, out_ready, flush,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready, flush,
    output in_ready, out_data, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
// +----------------------------------------------------------------------------+
// | Module : pipe_stage_skid_reg                                               |
// | Brief  : registered pipe stage, 2-entry skid, flush to NOP bubble.         |
// |          Optional stall/flush counters under PIPE_STAGE_STATS_EN.          |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_stage_skid_reg #(
  parameter int              BITS        = 32,
  parameter logic [BITS-1:0] FLUSH_VALUE = BITS'(32'h0000_0013)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  pipe_stage_skid_reg_if.slave   bus
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          r_state;
  logic [BITS-1:0] r_main;
  logic [BITS-1:0] r_skid;
  logic            r_out_valid;
  logic            r_skid_valid;

  logic            w_in_fire;
  logic            w_out_fire;

  // in_ready comes only from a flop, so out_ready never reaches it combinationally
  assign bus.in_ready  = ~r_skid_valid;
  assign bus.out_data  = r_main;
  assign bus.out_valid = r_out_valid;

  assign w_in_fire  = bus.in_valid & ~r_skid_valid;
  assign w_out_fire = r_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_main       <= FLUSH_VALUE;
      r_skid       <= FLUSH_VALUE;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (bus.flush) begin
      r_state      <= ST_EMPTY;
      r_main       <= FLUSH_VALUE;
      r_skid       <= FLUSH_VALUE;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state     <= ST_HALF;
            r_main      <= bus.in_data;
            r_out_valid <= 1'b1;
          end
        end
        ST_HALF: begin
          case ({w_in_fire, w_out_fire})
            2'b11: r_main <= bus.in_data;
            2'b10: begin
              r_state      <= ST_FULL;
              r_skid       <= bus.in_data;
              r_skid_valid <= 1'b1;
            end
            2'b01: begin
              r_state     <= ST_EMPTY;
              r_main      <= FLUSH_VALUE;
              r_out_valid <= 1'b0;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          if (w_out_fire) begin
            r_state      <= ST_HALF;
            r_main       <= r_skid;
            r_skid       <= FLUSH_VALUE;
            r_skid_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_EMPTY;
          r_main       <= FLUSH_VALUE;
          r_skid       <= FLUSH_VALUE;
          r_out_valid  <= 1'b0;
          r_skid_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // flush_cnt only counts flushes that actually discard a held beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (r_out_valid && !bus.out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.flush && (r_out_valid || r_skid_valid)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire
